// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that shares one 8-bit ripple-carry adder among N_REQ requesters.
// Define ADDER_ARB_STATS_EN to add the saturating 16-bit op_count output.
module adder_rc_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] s
);
  logic [8:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign s[8] = c[8];
endmodule

module adder_rr_arbiter #(
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_a,
  input  logic [8*N_REQ-1:0]         req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [8:0]                 rsp_sum,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  input  logic                       rsp_ready
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [15:0]                op_count
`endif
);
  localparam int IDW = $clog2(N_REQ);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] pend_id_q, pend_id_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [8:0]     rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [8:0]     add_s;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW:0]   cand;
  logic [N_REQ-1:0] gnt_oh;
  logic           accept;

  // Operands reach the adder only through the op registers.
  adder_rc_8 u_add (.a(op_a_q), .b(op_b_q), .s(add_s));

  // Search upward from the pointer, wrapping modulo N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (IDW+1)'(ptr_q) + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
      if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
    gnt_oh = '0;
    if (gnt_found && state_q == IDLE && !reset) gnt_oh[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt_oh;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    pend_id_d   = pend_id_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: if (accept) begin
        op_a_d    = req_a[8*gnt_idx +: 8];
        op_b_d    = req_b[8*gnt_idx +: 8];
        pend_id_d = gnt_idx;
        ptr_d     = (32'(gnt_idx) == N_REQ-1) ? '0 : gnt_idx + 1'b1;
        cnt_d     = 4'(SETTLE_CYCLES-1);
        state_d   = SETTLE;
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_sum_d   = add_s;
          rsp_id_d    = pend_id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      pend_id_q   <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pend_id_q   <= pend_id_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] op_count_q, op_count_d;
  always_comb begin
    op_count_d = op_count_q;
    if (rsp_valid_q && rsp_ready && op_count_q != 16'hFFFF) op_count_d = op_count_q + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) op_count_q <= '0;
    else       op_count_q <= op_count_d;
  end
  assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter (N_REQ=4, SETTLE_CYCLES=2).
module tb_adder_rr_arbiter;
  localparam int N = 4;
  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [8:0]     rsp_sum;
  logic [1:0]     rsp_id;
  logic           rsp_ready;
`ifdef ADDER_ARB_STATS_EN
  logic [15:0]    op_count;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  adder_rr_arbiter #(.N_REQ(N), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready)
`ifdef ADDER_ARB_STATS_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  // Ticks until rsp_valid, returning edges taken (99 on timeout).
  task automatic wait_rsp(output int lat);
    lat = 99;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Single requester op from IDLE with rsp_ready=1; leaves bench in IDLE.
  task automatic single_op(input string tag, input int i, input logic [7:0] a,
                           input logic [7:0] b, input logic [8:0] exp);
    int lat;
    set_op(i, a, b);
    req_valid = '0;
    req_valid[i] = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_gnt"}, 32'(req_ready), 32'(1 << i));
    tick();
    req_valid = '0;
    wait_rsp(lat);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_sum"}, 32'(rsp_sum), 32'(exp));
    chk({tag, "_id"}, 32'(rsp_id), i);
    tick();
  endtask

  initial begin
    int lat, c_prev, c_acc, rises;
    logic [1:0] exp_ids [5];
    exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    reset = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    tick(); tick();
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_sum", 32'(rsp_sum), 0);
    chk("rst_id", 32'(rsp_id), 0);
    reset = 1'b0; req_valid = '0;

    // requester 2 alone
    single_op("r2", 2, 8'h12, 8'h34, 9'h046);
    req_valid = 4'b0001;
    #1;
    chk("r2_idle_after", 32'(req_ready), 32'h1);
    req_valid = '0;

    // all valid from pointer 0: grants 0,1,2,3,0 spaced 4 cycles
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, 8'(8'h10*i + 1), 8'(8'h20 + i));
    req_valid = '1; rsp_ready = 1'b1;
    c_prev = 0;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("rr_gnt", 32'(req_ready), 32'(1 << exp_ids[n]));
      tick();
      c_acc = cyc;
      if (n > 0) chk("rr_spacing", c_acc - c_prev, 4);
      c_prev = c_acc;
      wait_rsp(lat);
      chk("rr_id", 32'(rsp_id), 32'(exp_ids[n]));
      chk("rr_sum", 32'(rsp_sum), 32'(8'h10*exp_ids[n] + 1) + 32'(8'h20 + exp_ids[n]));
      tick();
    end
    req_valid = '0;

    // arithmetic corners on requester 0 (pointer=1, search wraps to 0)
    single_op("ff_ff", 0, 8'hFF, 8'hFF, 9'h1FE);
    single_op("80_80", 0, 8'h80, 8'h80, 9'h100);
    single_op("00_00", 0, 8'h00, 8'h00, 9'h000);

    // back-pressure: rsp_ready low 5 cycles with requests pending (pointer=1)
    set_op(1, 8'h05, 8'h07);
    req_valid = 4'b0010; rsp_ready = 1'b0;
    tick();
    req_valid = '1;
    wait_rsp(lat);
    chk("bp_lat", lat, 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_sum", 32'(rsp_sum), 32'h00C);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_released", 32'(rsp_valid), 0);
    chk("bp_next_gnt", 32'(req_ready), 32'h4);
    tick();
    chk("bp_accepted", 32'(req_ready), 0);
    req_valid = '0;
    wait_rsp(lat);
    chk("bp_next_id", 32'(rsp_id), 2);
    tick();

    // operands changed after accept (pointer=3)
    set_op(3, 8'h21, 8'h43);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    set_op(3, 8'hFF, 8'hFF);
    wait_rsp(lat);
    chk("hold_sum", 32'(rsp_sum), 32'h064);
    chk("hold_id", 32'(rsp_id), 3);
    tick();

    // reset one cycle into SETTLE drops the op (pointer=0, dropped request 1 never latched)
    req_valid = 4'b0010;
    #1;
    chk("drop_gnt", 32'(req_ready), 32'h2);
    req_valid = '0;
    set_op(1, 8'h11, 8'h22);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_mid_valid", 32'(rsp_valid), 0);
    rises = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_valid) rises++;
    end
    chk("rst_mid_no_rsp", rises, 0);
    req_valid = '1;
    #1;
    chk("rst_mid_gnt", 32'(req_ready), 32'h1);
    req_valid = '0;

`ifdef ADDER_ARB_STATS_EN
    reset = 1'b1; tick(); reset = 1'b0;
    chk("stat_rst", 32'(op_count), 0);
    single_op("s1", 0, 8'h01, 8'h01, 9'h002);
    single_op("s2", 1, 8'h02, 8'h02, 9'h004);
    single_op("s3", 2, 8'h03, 8'h03, 9'h006);
    chk("stat_three", 32'(op_count), 3);
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    single_op("s4", 3, 8'h04, 8'h04, 9'h008);
    chk("stat_sat", 32'(op_count), 32'hFFFF);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("stat_clr", 32'(op_count), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one adder_rc_8 instance (8-bit A/B operands, 9-bit sum) among N_REQ requesters.
- Round-robin grant, valid/ready request and response handshakes.
- Multicycle settle counter so the ripple-carry path is never sampled early.
- Sits between client blocks and the shared adder; the adder is instantiated inside this block.

Parameters:
N_REQ, 4, number of requesters; 2..8; ID width IDW = clog2(N_REQ).
SETTLE_CYCLES, 2, cycles operands are held on the adder before the sum is captured; legal range 1..15.

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_a  in  8*N_REQ  operand A; requester i on bits [8i+7:8i]
req_b  in  8*N_REQ  operand B; same packing as req_a
req_ready  out  N_REQ  one-hot accept strobe
rsp_valid  out  1  result valid
rsp_sum  out  9  registered sum; bit 8 = carry out
rsp_id  out  IDW  index of the requester that owns rsp_sum
rsp_ready  in  1  response consumer ready

Behaviour:
- Reset (synchronous, active-high, on the clk edge):
  - state=IDLE, rr pointer=0, rsp_valid=0, rsp_sum=0, rsp_id=0, settle count=0, op registers=0.
  - req_ready=0 for the cycle reset is asserted.
- FSM states IDLE, SETTLE, RESP.
- IDLE:
  - Grant search starts at the pointer and goes upward, modulo N_REQ. The first i with req_valid[i]=1 wins.
  - req_ready[winner]=1 combinationally, and only in IDLE. All other bits are 0. With no valid request, all bits are 0.
  - Accept edge: req_valid[i]&req_ready[i].
  - On accept: latch req_a/req_b slice i into op_a/op_b, store i as pending id, set pointer=(i+1) mod N_REQ, set count=SETTLE_CYCLES-1, go to SETTLE.
- Adder inputs are driven only from the op_a/op_b registers, never directly from request ports.
- SETTLE:
  - Each edge with count!=0 decrements count.
  - On the edge with count==0: rsp_sum<=adder S, rsp_id<=pending id, rsp_valid<=1, go to RESP.
  - Result: rsp_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- RESP:
  - rsp_sum and rsp_id hold stable while rsp_valid=1 and rsp_ready=0.
  - Edge with rsp_ready=1: rsp_valid<=0, go to IDLE.
  - No new request is accepted on that same edge. The earliest next accept is the following edge.
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles.
- Arithmetic: rsp_sum = {1'b0,op_a}+{1'b0,op_b}, full 9 bits. No wrap; 0xFF+0xFF=0x1FE.
- Boundary conditions:
  - Pointer wraps from N_REQ-1 to 0.
  - All requesters valid: grants go 0,1,2,...,N_REQ-1,0.
  - A requester may drop req_valid before it is granted; nothing is latched.
  - req_a/req_b changes after accept do not affect the in-flight result.
  - Reset during SETTLE or RESP discards the in-flight op. rsp_valid=0 and state=IDLE after that edge, with no response emitted.
  - SETTLE_CYCLES=1: SETTLE lasts one cycle.

Optional Feature:
- Macro ADDER_ARB_STATS_EN.
- Defined:
  - Adds output port op_count (16 bits).
  - Reset to 0.
  - Increments on each rsp_valid&rsp_ready edge.
  - Saturates at 0xFFFF.
  - Cleared by reset mid-run like all other state.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then requester 2 only, A=0x12, B=0x34, rsp_ready=1 -> req_ready=0100 in the accept cycle; rsp_valid high 2 edges later with rsp_sum=0x046, rsp_id=2; IDLE one edge after that.
- All 4 requesters held valid continuously with distinct operands, rsp_ready=1 -> grant order 0,1,2,3,0; each response id/sum matches; accepts spaced exactly 4 cycles apart (SETTLE_CYCLES=2).
- A=0xFF, B=0xFF on requester 0 -> rsp_sum=0x1FE; A=0x80, B=0x80 -> 0x100; A=0, B=0 -> 0x000.
- rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_sum/rsp_id stable, req_ready stays 0000 despite pending requests; one accept occurs on the edge after rsp_ready=1 handshakes.
- Operands changed the cycle after accept, and reset asserted 1 cycle into SETTLE -> the first case still returns the latched sum; the reset case returns no response, rsp_valid=0, and the next grant goes to requester 0.
- With ADDER_ARB_STATS_EN defined: 3 completed ops give op_count=3; forcing the count to 0xFFFF and completing one more op keeps it at 0xFFFF; reset gives 0.
